// File: rtl/motor_pkg.sv
// Shared types and constants for the ramp-start speed-level interface.
// Imported by the speed-select FSM and by the PWM ramp consumer.
package motor_pkg;

  localparam int DUTY_W    = 7;
  localparam int PWM_STEPS = 100;

  localparam logic [DUTY_W-1:0] DUTY_0   = 7'd0;
  localparam logic [DUTY_W-1:0] DUTY_30  = 7'd30;
  localparam logic [DUTY_W-1:0] DUTY_50  = 7'd50;
  localparam logic [DUTY_W-1:0] DUTY_100 = 7'd100;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } state_e;

  // Ramp state implied by a duty/target pair.
  function automatic state_e classify(input logic [DUTY_W-1:0] duty,
                                      input logic [DUTY_W-1:0] target);
    if (duty < target)
      return RAMP_UP;
    else if (duty > target)
      return RAMP_DOWN;
    else if (target == DUTY_0)
      return IDLE;
    else
      return HOLD;
  endfunction

endpackage

// File: rtl/motor_pwm_rampa_pwm_gen.sv
// PWM generator: prescaler, 0..99 phase counter and a duty copy that is
// refreshed only at the phase wrap so every PWM period is whole.
module pwm_gen
  import motor_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     presc_reg;
  logic [DUTY_W-1:0] phase_reg;
  logic [DUTY_W-1:0] duty_latched_reg;
  logic              tick;
  logic              wrap;

  assign tick = (presc_reg == PW'(PRESCALE - 1));
  assign wrap = tick && (phase_reg == DUTY_W'(PWM_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg        <= '0;
      phase_reg        <= '0;
      duty_latched_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick)
        phase_reg <= wrap ? '0 : phase_reg + 1'b1;
      if (wrap)
        duty_latched_reg <= duty;
    end
  end

  // Phase never exceeds 99, so duty 100 is constant high and duty 0 constant low.
  assign pwm_out = (phase_reg < duty_latched_reg);

endmodule

// File: rtl/motor_pwm_rampa.sv
// Speed-command consumer: decodes one-hot speed commands into a duty target
// and slew-limits the duty in both directions before driving the PWM stage.
module motor_pwm_rampa
  import motor_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_30,
  input  logic              in_50,
  input  logic              in_100,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target,
  output logic              cmd_error
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  logic [2:0]        cmd_reg;
  logic [DUTY_W-1:0] target_reg, target_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic [TW-1:0]     timer_reg, timer_next;
  state_e            state_reg, state_next;
  logic              multi_cmd;

  // Commands are registered first; the target follows from the registered copy.
  assign multi_cmd = ((cmd_reg & (cmd_reg - 3'd1)) != 3'd0);

  always_comb begin
    target_next = target_reg;
    case (cmd_reg)
      3'b000:  target_next = DUTY_0;
      3'b001:  target_next = DUTY_30;
      3'b010:  target_next = DUTY_50;
      3'b100:  target_next = DUTY_100;
      default: target_next = target_reg;
    endcase
  end

  // Step direction follows the incoming target, so a terminal count that
  // coincides with a target change steps toward the new target (or not at all).
  always_comb begin
    duty_next  = duty_reg;
    timer_next = '0;
    if (state_reg == RAMP_UP || state_reg == RAMP_DOWN) begin
      if (timer_reg == TIMER_LAST) begin
        timer_next = '0;
        if (duty_reg < target_next)
          duty_next = duty_reg + 1'b1;
        else if (duty_reg > target_next)
          duty_next = duty_reg - 1'b1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
    state_next = classify(duty_next, target_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_reg    <= '0;
      target_reg <= '0;
      duty_reg   <= '0;
      timer_reg  <= '0;
      state_reg  <= IDLE;
    end else begin
      cmd_reg    <= {in_100, in_50, in_30};
      target_reg <= target_next;
      duty_reg   <= duty_next;
      timer_reg  <= timer_next;
      state_reg  <= state_next;
    end
  end

  assign duty      = duty_reg;
  assign at_target = (duty_reg == target_reg);
  assign cmd_error = multi_cmd;

  pwm_gen #(
    .PRESCALE(PRESCALE)
  ) u_pwm_gen (
    .clk    (clk),
    .reset  (reset),
    .duty   (duty_reg),
    .pwm_out(pwm_out)
  );

endmodule

// File: tb/tb_motor_pwm_rampa.sv
// Scenario bench for motor_pwm_rampa: expected duty steps are queued when a
// command is driven and popped as the DUT duty output changes.
module tb_motor_pwm_rampa;
  import motor_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_30 = 1'b0, in_50 = 1'b0, in_100 = 1'b0;
  logic       pwm_out, at_target, cmd_error;
  logic [6:0] duty;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  motor_pwm_rampa #(.PRESCALE(1), .STEP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_30(in_30), .in_50(in_50), .in_100(in_100),
    .pwm_out(pwm_out), .duty(duty), .at_target(at_target), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (duty !== 7'd0) begin n_bad++; $display("FAIL rst_duty: got %0d want 0", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL rst_at_target: got %b want 1", at_target); end
    n_cmp++; if (cmd_error !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_error: got %b want 0", cmd_error); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (duty !== 7'd0 || at_target !== 1'b1) begin n_bad++; $display("FAIL idle_after_rst: duty %0d at %b want 0/1", duty, at_target); end
    $display("test_reset done");
  endtask

  task automatic test_ramp_30();
    int highs;
    @(negedge clk);
    in_30 = 1'b1;
    @(posedge clk);                 // command sampled here (edge N)
    repeat (120) @(posedge clk);
    #1;
    n_cmp++; if (duty !== 7'd29 || at_target !== 1'b0) begin n_bad++; $display("FAIL ramp30_n120: duty %0d at %b want 29/0", duty, at_target); end
    @(posedge clk);
    #1;
    n_cmp++; if (duty !== 7'd30 || at_target !== 1'b1) begin n_bad++; $display("FAIL ramp30_n121: duty %0d at %b want 30/1", duty, at_target); end
    repeat (150) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    n_cmp++; if (highs != 30) begin n_bad++; $display("FAIL pwm30_highs: got %0d want 30", highs); end
    $display("test_ramp_30 done, duty %0d", duty);
  endtask

  task automatic test_ramp_up_100();
    int prev, gap, cyc, e, highs;
    bit first;
    @(negedge clk);
    in_30 = 1'b0; in_100 = 1'b1;
    for (int v = 31; v <= 100; v++) exp_q.push_back(v);
    prev = int'(duty); gap = 0; cyc = 0; first = 1'b1;
    while (exp_q.size() > 0 && cyc < 1000) begin
      @(negedge clk); cyc++; gap++;
      if (int'(duty) != prev) begin
        e = exp_q.pop_front();
        n_cmp++; if (duty !== 7'(e)) begin n_bad++; $display("FAIL up_step: got %0d want %0d", duty, e); end
        n_cmp++; if (gap != (first ? 6 : 4)) begin n_bad++; $display("FAIL up_gap: got %0d want %0d at duty %0d", gap, first ? 6 : 4, e); end
        n_cmp++; if (at_target !== (e == 100)) begin n_bad++; $display("FAIL up_at_target: got %b want %b at duty %0d", at_target, e == 100, e); end
        prev = int'(duty); gap = 0; first = 1'b0;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL up_timeout: %0d steps missing want 0", exp_q.size()); end
    exp_q.delete();
    repeat (150) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    n_cmp++; if (highs != 100) begin n_bad++; $display("FAIL pwm100_highs: got %0d want 100", highs); end
    $display("test_ramp_up_100 done, duty %0d", duty);
  endtask

  task automatic test_ramp_down_stop();
    int prev, gap, cyc, e, highs;
    bit first;
    @(negedge clk);
    in_100 = 1'b0;
    for (int v = 99; v >= 0; v--) exp_q.push_back(v);
    prev = int'(duty); gap = 0; cyc = 0; first = 1'b1;
    while (exp_q.size() > 0 && cyc < 1000) begin
      @(negedge clk); cyc++; gap++;
      if (int'(duty) != prev) begin
        e = exp_q.pop_front();
        n_cmp++; if (duty !== 7'(e)) begin n_bad++; $display("FAIL down_step: got %0d want %0d", duty, e); end
        n_cmp++; if (gap != (first ? 6 : 4)) begin n_bad++; $display("FAIL down_gap: got %0d want %0d at duty %0d", gap, first ? 6 : 4, e); end
        prev = int'(duty); gap = 0; first = 1'b0;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL down_timeout: %0d steps missing want 0", exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL down_at_target: got %b want 1", at_target); end
    repeat (150) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL pwm0_highs: got %0d want 0", highs); end
    $display("test_ramp_down_stop done, duty %0d", duty);
  endtask

  task automatic test_cmd_error();
    int cyc;
    @(negedge clk);
    in_30 = 1'b1;
    cyc = 0;
    while (duty !== 7'd30 && cyc < 400) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    n_cmp++; if (duty !== 7'd30 || at_target !== 1'b1 || cmd_error !== 1'b0) begin n_bad++; $display("FAIL err_pre: duty %0d at %b err %b want 30/1/0", duty, at_target, cmd_error); end
    in_30 = 1'b0; in_50 = 1'b1; in_100 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (cmd_error !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1 cycle %0d", cmd_error, i); end
      n_cmp++; if (duty !== 7'd30 || at_target !== 1'b1) begin n_bad++; $display("FAIL err_hold: duty %0d at %b want 30/1 cycle %0d", duty, at_target, i); end
    end
    in_50 = 1'b0; in_100 = 1'b0; in_30 = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (cmd_error !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", cmd_error); end
    repeat (8) @(negedge clk);
    n_cmp++; if (duty !== 7'd30 || at_target !== 1'b1) begin n_bad++; $display("FAIL err_after: duty %0d at %b want 30/1", duty, at_target); end
    $display("test_cmd_error done, duty %0d", duty);
  endtask

  task automatic test_reverse_mid_ramp();
    int prev, cyc, e, max_seen;
    @(negedge clk);
    in_30 = 1'b0; in_50 = 1'b1;
    for (int v = 31; v <= 40; v++) exp_q.push_back(v);
    prev = int'(duty); cyc = 0; max_seen = prev;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (int'(duty) != prev) begin
        e = exp_q.pop_front();
        n_cmp++; if (duty !== 7'(e) || at_target !== 1'b0) begin n_bad++; $display("FAIL rev_up: duty %0d at %b want %0d/0", duty, at_target, e); end
        prev = int'(duty);
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rev_up_timeout: %0d steps missing want 0", exp_q.size()); end
    exp_q.delete();
    in_50 = 1'b0; in_30 = 1'b1;
    for (int v = 39; v >= 30; v--) exp_q.push_back(v);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (int'(duty) > max_seen) max_seen = int'(duty);
      if (int'(duty) != prev) begin
        e = exp_q.pop_front();
        n_cmp++; if (duty !== 7'(e) || at_target !== (e == 30)) begin n_bad++; $display("FAIL rev_down: duty %0d at %b want %0d/%b", duty, at_target, e, e == 30); end
        prev = int'(duty);
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rev_down_timeout: %0d steps missing want 0", exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (max_seen != 40) begin n_bad++; $display("FAIL rev_peak: got %0d want 40", max_seen); end
    repeat (10) @(negedge clk);
    n_cmp++; if (duty !== 7'd30) begin n_bad++; $display("FAIL rev_settle: got %0d want 30", duty); end
    $display("test_reverse_mid_ramp done, duty %0d", duty);
  endtask

  task automatic test_reset_mid_ramp();
    int prev, gap, cyc, e;
    bit first;
    @(negedge clk);
    in_30 = 1'b0;
    cyc = 0;
    while (duty !== 7'd17 && cyc < 400) begin @(negedge clk); cyc++; end
    n_cmp++; if (duty !== 7'd17) begin n_bad++; $display("FAIL rr_reach17: got %0d want 17", duty); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (duty !== 7'd0 || pwm_out !== 1'b0) begin n_bad++; $display("FAIL rr_async: duty %0d pwm %b want 0/0", duty, pwm_out); end
    n_cmp++; if (at_target !== 1'b1 || cmd_error !== 1'b0) begin n_bad++; $display("FAIL rr_flags: at %b err %b want 1/0", at_target, cmd_error); end
    in_50 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int v = 1; v <= 50; v++) exp_q.push_back(v);
    prev = 0; gap = 0; cyc = 0; first = 1'b1;
    while (exp_q.size() > 0 && cyc < 600) begin
      @(negedge clk); cyc++; gap++;
      if (int'(duty) != prev) begin
        e = exp_q.pop_front();
        n_cmp++; if (duty !== 7'(e)) begin n_bad++; $display("FAIL rr_step: got %0d want %0d", duty, e); end
        n_cmp++; if (gap != (first ? 6 : 4)) begin n_bad++; $display("FAIL rr_gap: got %0d want %0d at duty %0d", gap, first ? 6 : 4, e); end
        prev = int'(duty); gap = 0; first = 1'b0;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_timeout: %0d steps missing want 0", exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (at_target !== 1'b1) begin n_bad++; $display("FAIL rr_at_target: got %b want 1", at_target); end
    $display("test_reset_mid_ramp done, duty %0d", duty);
  endtask

  initial begin
    test_reset();
    test_ramp_30();
    test_ramp_up_100();
    test_ramp_down_stop();
    test_cmd_error();
    test_reverse_mid_ramp();
    test_reset_mid_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/motor_pwm_rampa.md
# motor_pwm_rampa

Consumer side of the ramp-start speed-level interface: takes the one-hot speed commands (30 %, 50 %, 100 %) produced by the ramp-start FSM and drives the motor power stage with a PWM signal. The duty cycle is slew-limited in both directions (soft ramp-up and soft ramp-down) so that abrupt command changes never reach the motor as step changes. Sits between the speed-select FSM and the gate-driver pin.

## Interface
- `PRESCALE`, default 1: clocks per PWM phase tick; a PWM period is 100 × PRESCALE clocks.
- `STEP_CYCLES`, default 4: clocks between successive 1 % duty changes while ramping; must be ≥ 1.
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high. Clears all state.
- `in_30`, input, 1: 30 % speed command.
- `in_50`, input, 1: 50 % speed command.
- `in_100`, input, 1: 100 % speed command.
- `pwm_out`, output, 1: PWM drive to the power stage.
- `duty`, output, 7: current ramped duty in percent, 0..100.
- `at_target`, output, 1: high when `duty` equals the decoded target.
- `cmd_error`, output, 1: high for any cycle on which the registered command has more than one bit set.

## Operation
- **Command decode** (registered, 1 cycle):
  - exactly one of in_30/in_50/in_100 set → target = 30/50/100;
  - none set → target = 0 (stop request, ramp down);
  - more than one set → target holds its previous value and `cmd_error` = 1 for that cycle.
- **Ramp FSM** states: IDLE (duty = 0, target = 0), RAMP_UP, RAMP_DOWN, HOLD (duty = target ≠ 0).
  - duty < target → RAMP_UP; duty > target → RAMP_DOWN; duty = target → HOLD, or IDLE if target = 0.
  - Target change mid-ramp: direction is re-evaluated on the next cycle, and the step timer is not cleared. Example: 50 → 30 while duty = 40 on the way up switches to RAMP_DOWN.
- **Step timer**: counts 0..STEP_CYCLES−1 in RAMP_UP/RAMP_DOWN and is held at 0 in IDLE/HOLD. On terminal count, duty moves ±1 toward target. Duty never overshoots and is saturated to 0..100.
- **PWM**:
  - The phase counter advances 0..99 once per prescale tick and wraps 99 → 0.
  - `pwm_out` = (phase < duty_latched).
  - duty_latched copies `duty` only at the wrap. Duty updates are therefore glitch-free and each period is whole.
  - duty 0 gives a constant-low output; duty 100 gives a constant-high output.
- `at_target` = (duty == target), combinational from registers.

## Timing
- **Reset values**: pwm_out = 0, duty = 0, at_target = 1, cmd_error = 0, state IDLE, phase = 0, prescaler = 0, step timer = 0, duty_latched = 0, target = 0.
- **Ramp timing**: command visible at the inputs on edge N gives target at N+1. The first duty step occurs at N+1+STEP_CYCLES. From rest, a full ramp to T takes 1 + T·STEP_CYCLES clocks.
- **Duty-to-output latency**: a duty change appears on pwm_out at the next phase wrap, at most 100·PRESCALE clocks later.
- **Reset mid-ramp**: outputs drop to their reset values immediately (asynchronous). Ramping resumes from 0 after reset deasserts.
- **Simultaneous events**: a step-timer terminal count on the same cycle as a target change applies the step in the new direction. If the new target equals the current duty, no step is applied.

## Structure
- **Shared package `motor_pkg`**:
  - state enum {IDLE, RAMP_UP, RAMP_DOWN, HOLD};
  - constants DUTY_30 = 7'd30, DUTY_50 = 7'd50, DUTY_100 = 7'd100, DUTY_W = 7, PWM_STEPS = 100.
  - The ramp-start FSM also imports this package.
- **Sub-module `pwm_gen`**: prescaler, phase counter, duty_latched register and compare. Inputs: clk, reset, duty. Output: pwm_out. The top level contains the decode, ramp FSM and step timer.

## Test plan
1. Reset, then in_30 = 1 with STEP_CYCLES = 4 and PRESCALE = 1 → duty = 30 and at_target = 1 exactly 121 clocks after the command. Once latched, pwm_out is high for 30 of every 100 clocks.
2. Hold at 30, then switch to in_100 → duty rises monotonically one step per 4 clocks to 100. After the next wrap, pwm_out is constant high.
3. At duty 100, drop all commands → RAMP_DOWN to 0, then IDLE. pwm_out is constant low after the first wrap following duty = 0.
4. in_50 and in_100 set together while holding at 30 → cmd_error = 1 for those cycles, target stays 30, duty stays 30.
5. Ramp toward 50; at duty = 40 switch to in_30 → the direction reverses without overshoot and the ramp settles at 30 (no duty value above 40 appears).
6. Assert reset mid-ramp (duty = 17) → pwm_out = 0 and duty = 0 asynchronously, before the next clock edge. After release with in_50 held, the ramp restarts from 0.
